// File: rtl/pc_print_tx.sv
// Print transmitter: queues characters and emits them as retired-PC beats into a
// print window, then emits one good/bad trap beat and stops until reset.
module pc_print_tx #(
    parameter int          DEPTH        = 8,
    parameter int          GAP_CYCLES   = 1,
    parameter logic [63:0] PRINT_BASE   = 64'h80000400,
    parameter logic [63:0] GOOD_TRAP_PC = 64'h0000000080000100,
    parameter logic [63:0] BAD_TRAP_PC  = 64'h0000000080000200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        chr_val,
    input  logic [7:0]  chr_data,
    output logic        chr_rdy,
    input  logic        good_req,
    input  logic        bad_req,
    output logic        pc_vld,
    output logic [63:0] pc,
    output logic        busy,
    output logic        done,
    output logic [15:0] char_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {ST_EMIT, ST_TRAP, ST_DONE} state_t;
    state_t state_reg, state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          good_pend_reg, bad_pend_reg;
    logic          pc_vld_reg;
    logic [63:0]   pc_reg;
    logic [15:0]   char_count_reg;

    logic empty, full, push, pop, trap_beat, trap_pend, gap_zero;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign trap_pend = good_pend_reg | bad_pend_reg;
    assign gap_zero  = (gap_cnt_reg == '0);
    assign push      = chr_val & chr_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Leave EMIT only when nothing is queued or arriving, so late characters precede the trap.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMIT: if (trap_pend && empty && gap_zero && !push) state_next = ST_TRAP;
            ST_TRAP: state_next = ST_DONE;
            default: state_next = ST_DONE;
        endcase
    end

    always_comb begin
        chr_rdy   = 1'b0;
        pop       = 1'b0;
        trap_beat = 1'b0;
        done      = 1'b0;
        case (state_reg)
            ST_EMIT: begin
                chr_rdy = !full && !rst;
                pop     = !empty && gap_zero;
            end
            ST_TRAP: trap_beat = 1'b1;
            default: done = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= chr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            gap_cnt_reg    <= '0;
            good_pend_reg  <= 1'b0;
            bad_pend_reg   <= 1'b0;
            pc_vld_reg     <= 1'b0;
            pc_reg         <= '0;
            char_count_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

            if (pop || trap_beat) begin
                gap_cnt_reg <= GAP_LOAD;
            end else if (!gap_zero) begin
                gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end

            // The trap beat consumes the pending flags; DONE ignores further requests.
            if (trap_beat) begin
                good_pend_reg <= 1'b0;
                bad_pend_reg  <= 1'b0;
            end else if (state_reg == ST_EMIT) begin
                good_pend_reg <= good_pend_reg | good_req;
                bad_pend_reg  <= bad_pend_reg | bad_req;
            end

            pc_vld_reg <= pop | trap_beat;
            if (pop) begin
                pc_reg <= PRINT_BASE | {55'b0, mem[rd_ptr_reg[AW-1:0]], 1'b0};
            end else if (trap_beat) begin
                pc_reg <= bad_pend_reg ? BAD_TRAP_PC : GOOD_TRAP_PC;
            end else begin
                pc_reg <= '0;
            end

            if (pop && char_count_reg != 16'hFFFF) begin
                char_count_reg <= char_count_reg + 1'b1;
            end
        end
    end

    assign pc_vld     = pc_vld_reg;
    assign pc         = pc_reg;
    assign char_count = char_count_reg;
    assign busy       = !empty || !gap_zero || trap_pend;

endmodule
